wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Writeback arbiter and sole driver of the register-file write port (we/waddr/wdata).
- Merges two result sources into the single registered write port:
  - the ALU result, which has fixed timing;
  - load completions from the memory controller, which arrive with variable latency.
- Formats load data (byte/halfword select, sign/zero extension) and buffers it in a small FIFO.
- A starvation counter guarantees loads drain while the ALU is busy.

Parameters:
- LD_FIFO_DEPTH, 4, load-result FIFO entries (power of 2, >=2).
- STARVE_LIMIT, 3, consecutive ALU-won cycles with a non-empty FIFO before the ALU is stalled.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- rdy  in  1  global ready; 0 freezes the block
- alu_valid  in  1  ALU result present this cycle
- alu_rd  in  5  ALU destination register
- alu_data  in  32  ALU result
- alu_stall  out  1  registered; ALU must hold its result and not advance
- ld_valid  in  1  load completion offered
- ld_ready  out  1  FIFO can accept (combinational, = !full && rdy)
- ld_rd  in  5  load destination register
- ld_raw  in  32  raw aligned memory word
- ld_funct3  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- ld_offset  in  2  byte address bits [1:0]
- we  out  1  register-file write enable
- waddr  out  5  register-file write address
- wdata  out  32  register-file write data
- ld_count  out  clog2(LD_FIFO_DEPTH)+1  FIFO occupancy
- pending_mask  out  32  registers with loads queued (optional feature)

Behaviour:
- Reset (rst=1 at posedge):
  - we=0, waddr=0, wdata=0, alu_stall=0.
  - FIFO empty, ld_count=0, starvation counter=0, pending_mask=0.
  - In-flight FIFO contents are discarded.
- rdy=0:
  - All registers hold; we/waddr/wdata hold their values (the register file ignores them).
  - ld_ready=0; alu_valid and ld_valid are ignored.
- Load acceptance (ld_valid && ld_ready):
  - Data is formatted at enqueue.
  - LB/LBU select byte ld_offset; LH/LHU select halfword ld_offset[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
  - Unlisted funct3 values are treated as LW.
- x0 writes: an ALU result with alu_rd=0 is consumed with no write. A load with ld_rd=0 is accepted but not enqueued.
- Arbitration, per rdy=1 cycle:
  - If alu_stall=0 and alu_valid: ALU wins. Next cycle we=1, waddr=alu_rd, wdata=alu_data (1-cycle latency).
  - Else if the FIFO is non-empty: pop the head. Next cycle we=1 with the head entry.
  - Else: we=0 next cycle.
- Load latency: accepted at cycle N gives we no earlier than N+2.
- Starvation counter:
  - Increments each cycle the ALU wins while the FIFO is non-empty.
  - Clears on any pop or when the FIFO is empty.
  - When it equals STARVE_LIMIT, alu_stall=1 for exactly the following cycle. In that cycle the FIFO head is popped and alu_valid is ignored; the ALU re-presents the next cycle.
- FIFO:
  - Circular pointers wrap at LD_FIFO_DEPTH.
  - Simultaneous push and pop keeps ld_count unchanged.
  - Full gives ld_ready=0. There is no same-cycle full-pop bypass.
- Pending writes, one per cycle, retire in acceptance order per source. ALU results may overtake buffered loads. Hazard logic uses pending_mask.

Optional Feature:
- Macro: WB_PENDING_SCOREBOARD_EN.
- Defined:
  - pending_mask bit r is set while at least one FIFO entry targets r.
  - Implemented as a per-register 2-bit-min counter of queued entries, incremented on push and decremented on pop (same-cycle push+pop to the same r leaves it unchanged).
  - Bit 0 is always 0.
- Undefined: pending_mask tied to 0 and no counter logic is instantiated.

Decomposition:
- Add to config.v:
  - load funct3 encodings (`LB .. `LHU);
  - WB_FIFO_DEPTH and WB_STARVE_LIMIT defaults.
- Reuse `RegBus, `RegAddrBus, `RegNum.
- One sub-module, wb_load_fifo: synchronous FIFO of {rd, data} with push/pop/full/empty/count, parameterised on depth.
- Load formatting and arbitration stay in wb_arbiter.

Test Plan:
- Reset: after rst, verify:
  - we=0, waddr=0, wdata=0, alu_stall=0, ld_count=0, pending_mask=0;
  - ld_ready=1 once rdy=1.
- ALU path: alu_valid, rd=5, data=0x1234 at cycle N -> we=1, waddr=5, wdata=0x1234 at N+1. With rd=0 -> we=0.
- Load formatting, ld_raw=0x80FF7F01:
  - LB off1 -> 0x0000007F;
  - LB off3 -> 0xFFFFFF80;
  - LHU off2 -> 0x000080FF;
  - LH off0 -> 0x00007F01;
  - LW -> 0x80FF7F01.
- Starvation: continuous alu_valid plus 1 queued load -> ALU wins 3 cycles, alu_stall=1 on the 4th, and the load is written on the cycle after the stall.
- Backpressure: push 4 loads with the ALU busy -> ld_ready=0, ld_count=4. A 5th ld_valid is not accepted. Pops then drain in order, and ld_ready returns to 1 after the first pop.
- rdy freeze: drop rdy mid-drain for 3 cycles -> we/waddr/wdata, ld_count and pending_mask all hold. Resume yields the identical write sequence. Scoreboard (macro on): two loads to r7 -> bit 7 stays set until the second pop.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared widths, load encodings, FIFO entry type and load formatter
package wb_arbiter_pkg;

  localparam int REG_W      = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_NUM    = 32;

  localparam int WB_FIFO_DEPTH   = 4;
  localparam int WB_STARVE_LIMIT = 3;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_W-1:0]      data;
  } ld_entry_t;

  // Byte/halfword select plus extension; any unlisted funct3 passes the word through.
  function automatic logic [REG_W-1:0] format_load(input logic [REG_W-1:0] raw,
                                                   input logic [2:0]       funct3,
                                                   input logic [1:0]       offset);
    logic [7:0]       b;
    logic [15:0]      h;
    logic [REG_W-1:0] r;
    case (offset)
      2'd0:    b = raw[7:0];
      2'd1:    b = raw[15:8];
      2'd2:    b = raw[23:16];
      default: b = raw[31:24];
    endcase
    h = offset[1] ? raw[31:16] : raw[15:0];
    case (funct3)
      F3_LB:   r = {{24{b[7]}}, b};
      F3_LH:   r = {{16{h[15]}}, h};
      F3_LBU:  r = {24'b0, b};
      F3_LHU:  r = {16'b0, h};
      default: r = raw;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/wb_load_fifo.sv
// rtl/wb_load_fifo.sv - synchronous FIFO of formatted load results {rd, data}
module wb_load_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  ld_entry_t              push_data,
  input  logic                   pop,
  output ld_entry_t              head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  ld_entry_t         mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage array; reset only clears the pointers, so stale contents are simply unreachable.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Circular pointers and occupancy; push+pop together leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - writeback arbiter driving the register-file write port (option: WB_PENDING_SCOREBOARD_EN)
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int LD_FIFO_DEPTH = WB_FIFO_DEPTH,
  parameter int STARVE_LIMIT  = WB_STARVE_LIMIT
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rdy,
  input  logic                           alu_valid,
  input  logic [REG_ADDR_W-1:0]          alu_rd,
  input  logic [REG_W-1:0]               alu_data,
  output logic                           alu_stall,
  input  logic                           ld_valid,
  output logic                           ld_ready,
  input  logic [REG_ADDR_W-1:0]          ld_rd,
  input  logic [REG_W-1:0]               ld_raw,
  input  logic [2:0]                     ld_funct3,
  input  logic [1:0]                     ld_offset,
  output logic                           we,
  output logic [REG_ADDR_W-1:0]          waddr,
  output logic [REG_W-1:0]               wdata,
  output logic [$clog2(LD_FIFO_DEPTH):0] ld_count,
  output logic [REG_NUM-1:0]             pending_mask
);

  localparam int CNT_W = $clog2(LD_FIFO_DEPTH) + 1;
  localparam int SW    = $clog2(STARVE_LIMIT + 1);

  logic          fifo_full;
  logic          fifo_empty;
  ld_entry_t     fifo_head;
  ld_entry_t     push_entry;
  logic          push;
  logic          pop;
  logic          alu_win;
  logic [SW-1:0] starve_cnt;
  logic [SW-1:0] starve_next;

  // Loads to x0 are handshaken but dropped; everything is frozen while rdy is low.
  assign ld_ready   = !fifo_full && rdy;
  assign push       = ld_valid && ld_ready && (ld_rd != '0);
  assign alu_win    = rdy && alu_valid && !alu_stall;
  assign pop        = rdy && !alu_win && !fifo_empty;
  assign push_entry = '{rd: ld_rd, data: format_load(ld_raw, ld_funct3, ld_offset)};

  wb_load_fifo #(
    .DEPTH(LD_FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(push_entry),
    .pop      (pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (ld_count)
  );

  // Count ALU wins that bypass a waiting load; any pop or an empty FIFO restarts the count.
  always_comb begin
    starve_next = starve_cnt;
    if (pop || fifo_empty) begin
      starve_next = '0;
    end else if (alu_win) begin
      starve_next = starve_cnt + SW'(1);
    end
  end

  // Reaching the limit stalls the ALU for one cycle, which forces a pop and clears the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      alu_stall  <= 1'b0;
    end else if (rdy) begin
      starve_cnt <= starve_next;
      alu_stall  <= (starve_next == SW'(STARVE_LIMIT));
    end
  end

  // Registered write port: ALU has priority, otherwise drain the FIFO head.
  always_ff @(posedge clk) begin
    if (rst) begin
      we    <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end else if (rdy) begin
      if (alu_win) begin
        we    <= (alu_rd != '0);
        waddr <= alu_rd;
        wdata <= alu_data;
      end else if (pop) begin
        we    <= 1'b1;
        waddr <= fifo_head.rd;
        wdata <= fifo_head.data;
      end else begin
        we    <= 1'b0;
      end
    end
  end

`ifdef WB_PENDING_SCOREBOARD_EN
  assign pending_mask[0] = 1'b0;

  genvar r;
  for (r = 1; r < REG_NUM; r++) begin : g_pend
    logic [CNT_W-1:0] cnt;
    logic             inc;
    logic             dec;

    assign inc             = push && (ld_rd == REG_ADDR_W'(r));
    assign dec             = pop && (fifo_head.rd == REG_ADDR_W'(r));
    assign pending_mask[r] = |cnt;

    // Number of queued entries targeting this register.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt <= '0;
      end else if (inc && !dec) begin
        cnt <= cnt + CNT_W'(1);
      end else if (dec && !inc) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end
`else
  assign pending_mask = '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - scoreboard bench for wb_arbiter (option: WB_PENDING_SCOREBOARD_EN)
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_stall;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_raw;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_offset;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [2:0]  ld_count;
  logic [31:0] pending_mask;

  int          total = 0;
  int          bad   = 0;
  logic [36:0] exp_q[$];
  logic        rdy_e = 1'b0;
  logic        rst_e = 1'b1;
  int          k;

`ifdef WB_PENDING_SCOREBOARD_EN
  localparam bit PEND_ON = 1'b1;
`else
  localparam bit PEND_ON = 1'b0;
`endif

  wb_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .alu_stall   (alu_stall),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_rd       (ld_rd),
    .ld_raw      (ld_raw),
    .ld_funct3   (ld_funct3),
    .ld_offset   (ld_offset),
    .we          (we),
    .waddr       (waddr),
    .wdata       (wdata),
    .ld_count    (ld_count),
    .pending_mask(pending_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] d);
    exp_q.push_back({rd, d});
  endtask

  function automatic logic [31:0] pend_exp(input logic [31:0] m);
    return PEND_ON ? m : 32'h0;
  endfunction

  // Remember whether the last edge was a live (rdy=1, rst=0) edge.
  always @(posedge clk) begin
    rdy_e <= rdy;
    rst_e <= rst;
  end

  // Every fresh write must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst_e && rdy_e && we) begin
      check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        logic [36:0] e;
        e = exp_q.pop_front();
        check("sb_waddr", {27'b0, waddr}, {27'b0, e[36:32]});
        check("sb_wdata", wdata, e[31:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [2:0]  f3_t  [5];
    logic [1:0]  off_t [5];
    logic [31:0] res_t [5];
    logic [4:0]  frz_rd[3];

    f3_t  = '{F3_LB, F3_LB, F3_LHU, F3_LH, F3_LW};
    off_t = '{2'd1, 2'd3, 2'd2, 2'd0, 2'd0};
    res_t = '{32'h0000007F, 32'hFFFFFF80, 32'h000080FF, 32'h00007F01, 32'h80FF7F01};
    frz_rd = '{5'd7, 5'd7, 5'd9};

    rst = 1'b1; rdy = 1'b1;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_raw = '0; ld_funct3 = F3_LW; ld_offset = '0;
    tick(); tick();
    check("rst_we",        32'(we), 32'd0);
    check("rst_waddr",     32'(waddr), 32'd0);
    check("rst_wdata",     wdata, 32'd0);
    check("rst_alu_stall", 32'(alu_stall), 32'd0);
    check("rst_ld_count",  32'(ld_count), 32'd0);
    check("rst_pending",   pending_mask, 32'd0);
    rst = 1'b0; rdy = 1'b0;
    #1 check("rdy0_ld_ready", 32'(ld_ready), 32'd0);
    rdy = 1'b1;
    #1 check("rdy1_ld_ready", 32'(ld_ready), 32'd1);
    tick();

    // ALU path, including a write to x0
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
    expect_wr(5'd5, 32'h1234);
    tick();
    check("alu_we", 32'(we), 32'd1);
    alu_rd = 5'd0; alu_data = 32'hDEAD;
    tick();
    check("alu_x0_we", 32'(we), 32'd0);
    alu_valid = 1'b0;
    tick();

    // Load formatting, back-to-back, plus first-load latency
    for (int i = 0; i < 5; i++) begin
      ld_valid = 1'b1; ld_rd = 5'(10 + i); ld_raw = 32'h80FF7F01;
      ld_funct3 = f3_t[i]; ld_offset = off_t[i];
      expect_wr(5'(10 + i), res_t[i]);
      tick();
      if (i == 0) check("ld_lat_n1", 32'(we), 32'd0);
      if (i == 1) check("ld_lat_n2", 32'(we), 32'd1);
    end
    ld_valid = 1'b0;
    repeat (4) tick();
    check("fmt_drain", 32'(exp_q.size()), 32'd0);

    // Load to x0 is accepted but never queued
    ld_valid = 1'b1; ld_rd = 5'd0; ld_funct3 = F3_LW; ld_raw = 32'h11111111;
    tick();
    ld_valid = 1'b0;
    check("ld_x0_count", 32'(ld_count), 32'd0);
    tick();
    check("ld_x0_we", 32'(we), 32'd0);

    // Starvation: one queued load behind a continuously busy ALU
    k = 0;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("starve_stall_%0d", i), 32'(alu_stall), 32'(i == 4));
      alu_valid = 1'b1; alu_rd = 5'(1 + k); alu_data = 32'hA000 + 32'(k);
      if (i == 0) begin
        ld_valid = 1'b1; ld_rd = 5'd20; ld_funct3 = F3_LW; ld_raw = 32'h5555AAAA;
      end else begin
        ld_valid = 1'b0;
      end
      if (i == 4) begin
        check("starve_count", 32'(ld_count), 32'd1);
        expect_wr(5'd20, 32'h5555AAAA);
      end else begin
        expect_wr(alu_rd, alu_data);
        k++;
      end
      tick();
    end
    alu_valid = 1'b0;
    check("starve_stall_clear", 32'(alu_stall), 32'd0);
    repeat (3) tick();
    check("starve_drain", 32'(exp_q.size()), 32'd0);

    // Backpressure: ALU busy with x0 results, FIFO fills, fifth load refused
    for (int i = 0; i < 5; i++) begin
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'(i);
      if (i > 0) check($sformatf("bp_count_%0d", i), 32'(ld_count), 32'(i));
      ld_valid = 1'b1; ld_rd = 5'(24 + i); ld_funct3 = F3_LW; ld_raw = 32'hB0000000 + 32'(i);
      if (i < 4) expect_wr(5'(24 + i), 32'hB0000000 + 32'(i));
      #1 check($sformatf("bp_ready_%0d", i), 32'(ld_ready), 32'(i < 4));
      if (i == 4) check("bp_stall", 32'(alu_stall), 32'd1);
      tick();
    end
    ld_valid = 1'b0; alu_valid = 1'b0;
    check("bp_count_after_pop", 32'(ld_count), 32'd3);
    #1 check("bp_ready_after_pop", 32'(ld_ready), 32'd1);
    repeat (5) tick();
    check("bp_drain", 32'(exp_q.size()), 32'd0);

    // rdy freeze in the middle of a drain
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h0;
      if (i < 3) begin
        ld_valid = 1'b1; ld_rd = frz_rd[i]; ld_funct3 = F3_LW; ld_raw = 32'hC0000000 + 32'(i);
        expect_wr(frz_rd[i], 32'hC0000000 + 32'(i));
      end else begin
        ld_valid = 1'b0;
      end
      tick();
    end
    check("frz_count_full3", 32'(ld_count), 32'd3);
    check("frz_pend_both", pending_mask, pend_exp(32'h0000_0280));
    alu_valid = 1'b0;
    tick();
    rdy = 1'b0;
    for (int j = 0; j < 3; j++) begin
      tick();
      check($sformatf("frz_we_%0d", j),    32'(we), 32'd1);
      check($sformatf("frz_waddr_%0d", j), 32'(waddr), 32'd7);
      check($sformatf("frz_wdata_%0d", j), wdata, 32'hC0000000);
      check($sformatf("frz_count_%0d", j), 32'(ld_count), 32'd2);
      check($sformatf("frz_pend_%0d", j),  pending_mask, pend_exp(32'h0000_0280));
    end
    rdy = 1'b1;
    tick();
    check("frz_resume_count", 32'(ld_count), 32'd1);
    check("frz_pend_r7_clear", pending_mask, pend_exp(32'h0000_0200));
    tick();
    check("frz_pend_empty", pending_mask, 32'h0);
    repeat (3) tick();
    check("final_drain", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
